// File: rtl/stack_pkg.sv
// Shared types for the parametrised LIFO stack: operation encoding and the
// push/pop request decoder used by the top level.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_SWAP
    } stack_op_t;

    function automatic stack_op_t decode_op(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_SWAP;
            default: return OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/stack_ptr_ctrl.sv
// Occupancy tracking for the LIFO: count register, status flags, accept/reject
// decisions and the registered overflow/underflow/error pulses.
module stack_ptr_ctrl
    import stack_pkg::*;
#(
    parameter int AddressSize     = 3,
    parameter int AlmostFullLevel = 6
) (
    input  logic                   Clk,
    input  logic                   RstN,
    input  logic                   Clear,
    input  stack_op_t              op,
    output logic [AddressSize:0]   Count,
    output logic                   Full,
    output logic                   Empty,
    output logic                   Almost_Full,
    output logic                   Overflow,
    output logic                   Underflow,
    output logic                   Error,
    output logic                   wr_en,
    output logic                   rd_en,
    output logic [AddressSize-1:0] wr_addr,
    output logic [AddressSize-1:0] top_addr
);

    localparam logic [AddressSize:0] DepthCount = (AddressSize+1)'(1 << AddressSize);
    localparam logic [AddressSize:0] AfLevel    = (AddressSize+1)'(AlmostFullLevel);

    logic [AddressSize:0] count_nxt;
    logic                 ovf_nxt;
    logic                 unf_nxt;

    // Wraps to DEPTH-1 when the stack is full, which is exactly the top slot.
    assign top_addr = Count[AddressSize-1:0] - 1'b1;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        count_nxt = Count;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wr_addr   = Count[AddressSize-1:0];
        if (Clear) begin
            count_nxt = '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (Full) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        count_nxt = Count + 1'b1;
                    end
                end
                OP_POP: begin
                    if (Empty) begin
                        unf_nxt = 1'b1;
                    end else begin
                        rd_en     = 1'b1;
                        count_nxt = Count - 1'b1;
                    end
                end
                OP_SWAP: begin
                    // An empty swap degrades to a plain push that still flags the missing pop.
                    if (Empty) begin
                        unf_nxt   = 1'b1;
                        wr_en     = 1'b1;
                        count_nxt = Count + 1'b1;
                    end else begin
                        rd_en   = 1'b1;
                        wr_en   = 1'b1;
                        wr_addr = top_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or posedge RstN) begin
        if (RstN) begin
            Count       <= '0;
            Full        <= 1'b0;
            Empty       <= 1'b1;
            Almost_Full <= 1'b0;
            Overflow    <= 1'b0;
            Underflow   <= 1'b0;
            Error       <= 1'b0;
        end else begin
            Count       <= count_nxt;
            Full        <= (count_nxt == DepthCount);
            Empty       <= (count_nxt == '0);
            Almost_Full <= (count_nxt >= AfLevel);
            Overflow    <= ovf_nxt;
            Underflow   <= unf_nxt;
            Error       <= ovf_nxt | unf_nxt;
        end
    end

endmodule

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with swap, clear, top-of-stack peek and error pulses.
// Storage and output data live here; counting and flags live in stack_ptr_ctrl.
module param_lifo_stack
    import stack_pkg::*;
#(
    parameter int WordSize        = 4,
    parameter int AddressSize     = 3,
    parameter int AlmostFullLevel = 6
) (
    input  logic                 Clk,
    input  logic                 RstN,
    input  logic                 Clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WordSize-1:0]  Data_In,
    output logic [WordSize-1:0]  Data_Out,
    output logic                 Valid_Out,
    output logic [WordSize-1:0]  Top,
    output logic [AddressSize:0] Count,
    output logic                 Full,
    output logic                 Empty,
    output logic                 Almost_Full,
    output logic                 Overflow,
    output logic                 Underflow,
    output logic                 Error
);

    localparam int Depth = 1 << AddressSize;

    logic [WordSize-1:0]    mem [Depth];
    stack_op_t              op;
    logic                   wr_en;
    logic                   rd_en;
    logic [AddressSize-1:0] wr_addr;
    logic [AddressSize-1:0] top_addr;

    assign op = decode_op(push, pop);

    stack_ptr_ctrl #(
        .AddressSize     (AddressSize),
        .AlmostFullLevel (AlmostFullLevel)
    ) u_ptr_ctrl (
        .Clk         (Clk),
        .RstN        (RstN),
        .Clear       (Clear),
        .op          (op),
        .Count       (Count),
        .Full        (Full),
        .Empty       (Empty),
        .Almost_Full (Almost_Full),
        .Overflow    (Overflow),
        .Underflow   (Underflow),
        .Error       (Error),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wr_addr     (wr_addr),
        .top_addr    (top_addr)
    );

    // NOTE: the storage array has no reset; Count alone decides which words are meaningful.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= Data_In;
        end
    end

    // On a swap this reads the pre-edge top word while the same edge overwrites it.
    always_ff @(posedge Clk or posedge RstN) begin
        if (RstN) begin
            Data_Out  <= '0;
            Valid_Out <= 1'b0;
        end else begin
            Valid_Out <= rd_en;
            if (rd_en) begin
                Data_Out <= mem[top_addr];
            end
        end
    end

    assign Top = Empty ? '0 : mem[top_addr];

endmodule

// File: tb/tb_param_lifo_stack.sv
// Self-checking bench for param_lifo_stack: directed stimulus, with popped data
// scored by a monitor against an expected-data queue.
module tb_param_lifo_stack;

    logic       Clk = 1'b0;
    logic       RstN;
    logic       Clear;
    logic       push;
    logic       pop;
    logic [3:0] Data_In;
    logic [3:0] Data_Out;
    logic       Valid_Out;
    logic [3:0] Top;
    logic [3:0] Count;
    logic       Full;
    logic       Empty;
    logic       Almost_Full;
    logic       Overflow;
    logic       Underflow;
    logic       Error;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] exp_q [$];

    param_lifo_stack #(
        .WordSize        (4),
        .AddressSize     (3),
        .AlmostFullLevel (6)
    ) dut (
        .Clk         (Clk),
        .RstN        (RstN),
        .Clear       (Clear),
        .push        (push),
        .pop         (pop),
        .Data_In     (Data_In),
        .Data_Out    (Data_Out),
        .Valid_Out   (Valid_Out),
        .Top         (Top),
        .Count       (Count),
        .Full        (Full),
        .Empty       (Empty),
        .Almost_Full (Almost_Full),
        .Overflow    (Overflow),
        .Underflow   (Underflow),
        .Error       (Error)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every Valid_Out pulse must match the oldest expected popped word.
    always @(negedge Clk) begin
        if (Valid_Out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid_out", 32'(Data_Out), 32'hFFFF_FFFF);
            end else begin
                check("popped_data", 32'(Data_Out), 32'(exp_q.pop_front()));
            end
        end
    end

    // Apply one operation across one rising edge; outputs are checked 1 time unit later.
    task automatic step(input logic p, input logic q, input logic [3:0] d, input logic clr);
        push    = p;
        pop     = q;
        Data_In = d;
        Clear   = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic check_pulses(input string tag, input logic v, input logic o, input logic u);
        check({tag, "_valid"},     32'(Valid_Out), 32'(v));
        check({tag, "_overflow"},  32'(Overflow),  32'(o));
        check({tag, "_underflow"}, 32'(Underflow), 32'(u));
        check({tag, "_error"},     32'(Error),     32'(o | u));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RstN = 1'b1; Clear = 1'b0; push = 1'b0; pop = 1'b0; Data_In = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b0;
        #1;
        check("rst_count", 32'(Count), 0);
        check("rst_empty", 32'(Empty), 1);
        check("rst_full", 32'(Full), 0);
        check("rst_afull", 32'(Almost_Full), 0);
        check("rst_dout", 32'(Data_Out), 0);
        check("rst_top", 32'(Top), 0);
        check_pulses("rst", 1'b0, 1'b0, 1'b0);

        // 1: fill to full, then one rejected push
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 4'(i), 1'b0);
            check("fill_count", 32'(Count), 32'(i));
            check("fill_top", 32'(Top), 32'(i));
            check("fill_afull", 32'(Almost_Full), 32'(i >= 6));
            check("fill_full", 32'(Full), 32'(i == 8));
        end
        step(1'b1, 1'b0, 4'd9, 1'b0);
        check_pulses("ovf", 1'b0, 1'b1, 1'b0);
        check("ovf_count", 32'(Count), 8);
        check("ovf_top", 32'(Top), 8);
        idle();
        check_pulses("ovf_after", 1'b0, 1'b0, 1'b0);

        // 2: drain, then one rejected pop
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(4'(9 - i));
            step(1'b0, 1'b1, 4'd0, 1'b0);
            check("drain_valid", 32'(Valid_Out), 1);
            check("drain_count", 32'(Count), 32'(8 - i));
        end
        check("drain_empty", 32'(Empty), 1);
        check("drain_afull", 32'(Almost_Full), 0);
        step(1'b0, 1'b1, 4'd0, 1'b0);
        check_pulses("unf", 1'b0, 1'b0, 1'b1);
        check("unf_dout_hold", 32'(Data_Out), 1);
        check("unf_count", 32'(Count), 0);
        idle();

        // 3: swap on a non-empty stack
        step(1'b1, 1'b0, 4'd3, 1'b0);
        step(1'b1, 1'b0, 4'd5, 1'b0);
        exp_q.push_back(4'd5);
        step(1'b1, 1'b1, 4'd9, 1'b0);
        check_pulses("swap", 1'b1, 1'b0, 1'b0);
        check("swap_dout", 32'(Data_Out), 5);
        check("swap_top", 32'(Top), 9);
        check("swap_count", 32'(Count), 2);
        exp_q.push_back(4'd9);
        step(1'b0, 1'b1, 4'd0, 1'b0);
        check("swap_pop_dout", 32'(Data_Out), 9);
        check("swap_pop_top", 32'(Top), 3);
        exp_q.push_back(4'd3);
        step(1'b0, 1'b1, 4'd0, 1'b0);
        check("swap_drain_empty", 32'(Empty), 1);

        // 4: swap on an empty stack acts as push plus underflow
        step(1'b1, 1'b1, 4'd7, 1'b0);
        check_pulses("eswap", 1'b0, 1'b0, 1'b1);
        check("eswap_count", 32'(Count), 1);
        check("eswap_top", 32'(Top), 7);
        exp_q.push_back(4'd7);
        step(1'b0, 1'b1, 4'd0, 1'b0);
        check("eswap_pop_dout", 32'(Data_Out), 7);

        // 5: Clear beats a simultaneous push
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'(10 + i), 1'b0);
        check("clr_pre_count", 32'(Count), 4);
        step(1'b1, 1'b0, 4'd15, 1'b1);
        check("clr_count", 32'(Count), 0);
        check("clr_empty", 32'(Empty), 1);
        check("clr_top", 32'(Top), 0);
        check("clr_dout_hold", 32'(Data_Out), 7);
        check_pulses("clr", 1'b0, 1'b0, 1'b0);

        // 6: asynchronous reset between edges in the middle of pushes
        step(1'b1, 1'b0, 4'd1, 1'b0);
        step(1'b1, 1'b0, 4'd2, 1'b0);
        step(1'b1, 1'b0, 4'd3, 1'b0);
        check("arst_pre_count", 32'(Count), 3);
        Data_In = 4'd4;
        #2;
        RstN = 1'b1;
        #1;
        check("arst_count", 32'(Count), 0);
        check("arst_empty", 32'(Empty), 1);
        check("arst_top", 32'(Top), 0);
        check("arst_dout", 32'(Data_Out), 0);
        #1;
        RstN    = 1'b0;
        Data_In = 4'd2;
        @(posedge Clk);
        #1;
        check("arst_post_count", 32'(Count), 1);
        check("arst_post_top", 32'(Top), 2);
        idle();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
